// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   localparam logic [5:0] MDU_TIMEOUT = 6'd63;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one execute-stage source register.
module fwd_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rd_m_i,
   input  logic       regwrite_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       regwrite_w_i,
   output fwd_sel_t   fwd_o
);

   logic matchM;
   logic matchW;

   // x0 is hardwired zero, so a write to it must never be forwarded
   assign matchM = regwrite_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i);
   assign matchW = regwrite_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i);

   always_comb begin
      fwd_o = FWD_RF;
      if (matchM) begin
         fwd_o = FWD_MEM;
      end else if (matchW) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding and MDU wait tracking.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1_d,
   input  logic [4:0]  rs2_d,
   input  logic [4:0]  rs1_e,
   input  logic [4:0]  rs2_e,
   input  logic [4:0]  rd_e,
   input  logic        memread_e,
   input  logic [4:0]  rd_m,
   input  logic [4:0]  rd_w,
   input  logic        regwrite_m,
   input  logic        regwrite_w,
   input  logic        branch_taken_e,
   input  logic        mdu_start_e,
   input  logic        mdu_done,
   output logic        stall_f,
   output logic        stall_d,
   output logic        stall_e,
   output logic        flush_d,
   output logic        flush_e,
   output logic        flush_m,
   output logic [1:0]  fwd_a_e,
   output logic [1:0]  fwd_b_e,
   output logic [31:0] stall_cycles,
   output logic [15:0] redirects,
   output logic        mdu_timeout
);

   hz_state_t   state_q, state_d;
   logic [5:0]  waitCnt_q, waitCnt_d;
   logic [31:0] stallCnt_q, stallCnt_d;
   logic [15:0] redirCnt_q, redirCnt_d;
   logic        timeout_q, timeout_d;
   logic        loadUse;
   logic        redirect;
   fwd_sel_t    fwdA, fwdB;

   fwd_unit u_fwd_a (
      .rs_i         (rs1_e),
      .rd_m_i       (rd_m),
      .regwrite_m_i (regwrite_m),
      .rd_w_i       (rd_w),
      .regwrite_w_i (regwrite_w),
      .fwd_o        (fwdA)
   );

   fwd_unit u_fwd_b (
      .rs_i         (rs2_e),
      .rd_m_i       (rd_m),
      .regwrite_m_i (regwrite_m),
      .rd_w_i       (rd_w),
      .regwrite_w_i (regwrite_w),
      .fwd_o        (fwdB)
   );

   assign fwd_a_e = reset ? FWD_RF : fwdA;
   assign fwd_b_e = reset ? FWD_RF : fwdB;

   assign loadUse = memread_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         waitCnt_q  <= '0;
         stallCnt_q <= '0;
         redirCnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         stallCnt_q <= stallCnt_d;
         redirCnt_q <= redirCnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Priority in RUN: redirect, then MDU start, then load-use; MDU_BUSY ignores branches
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      timeout_d = timeout_q;
      redirect  = 1'b0;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;

      case (state_q)
         RUN: begin
            if (branch_taken_e) begin
               flush_d  = 1'b1;
               flush_e  = 1'b1;
               redirect = 1'b1;
            end else if (mdu_start_e) begin
               stall_f   = 1'b1;
               stall_d   = 1'b1;
               stall_e   = 1'b1;
               flush_m   = 1'b1;
               state_d   = MDU_BUSY;
               waitCnt_d = '0;
            end else if (loadUse) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         MDU_BUSY: begin
            if (mdu_done) begin
               state_d   = RUN;
               waitCnt_d = '0;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
               if (waitCnt_q == MDU_TIMEOUT) begin
                  timeout_d = 1'b1;
                  state_d   = RUN;
                  waitCnt_d = '0;
               end else begin
                  waitCnt_d = waitCnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d   = RUN;
            waitCnt_d = '0;
         end
      endcase

      if (reset) begin
         redirect = 1'b0;
         stall_f  = 1'b0;
         stall_d  = 1'b0;
         stall_e  = 1'b0;
         flush_d  = 1'b1;
         flush_e  = 1'b1;
         flush_m  = 1'b1;
      end

      stallCnt_d = stallCnt_q;
      if (stall_f && (stallCnt_q != '1)) begin
         stallCnt_d = stallCnt_q + 32'd1;
      end
      redirCnt_d = redirCnt_q;
      if (redirect && (redirCnt_q != '1)) begin
         redirCnt_d = redirCnt_q + 16'd1;
      end
   end

   assign stall_cycles = stallCnt_q;
   assign redirects    = redirCnt_q;
   assign mdu_timeout  = timeout_q;

endmodule
